// File: rtl/primefact.sv
// primefact: sequential prime factoriser.
// Trial division by d = 2, 3, 5, 7, ... using a restoring shift-subtract
// divider (one quotient bit per cycle). Prime factors are streamed out in
// non-decreasing order over a valid/ready handshake, with multiplicity,
// and the final factor is flagged with out_last.
module primefact #(
  parameter int WIDTH_LOG = 4,
  localparam int W = 2 ** WIDTH_LOG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] num,
  output logic         ready,
  output logic         error,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] factor,
  output logic         out_last
);

  localparam logic [W-1:0]         D_TWO    = W'(2);
  localparam logic [W-1:0]         D_THREE  = W'(3);
  localparam logic [W-1:0]         Q_ONE    = W'(1);
  localparam logic [2*W-1:0]       SQ_FOUR  = (2*W)'(4);
  localparam logic [2*W-1:0]       SQ_NINE  = (2*W)'(9);
  localparam logic [WIDTH_LOG-1:0] CNT_LAST = {WIDTH_LOG{1'b1}};
  localparam logic [WIDTH_LOG-1:0] CNT_ONE  = WIDTH_LOG'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ERROR     = 3'd1,
    CHECK     = 3'd2,
    DIV       = 3'd3,
    EMIT      = 3'd4,
    EMIT_LAST = 3'd5
  } state_t;

  state_t               state;
  logic [W-1:0]         n;    // remaining cofactor
  logic [W-1:0]         d;    // current trial divisor
  logic [2*W-1:0]       dsq;  // d*d, wide enough never to overflow
  logic [W-1:0]         q;    // dividend shifting out / quotient shifting in
  logic [W-1:0]         r;    // partial remainder, always < d
  logic [WIDTH_LOG-1:0] cnt;  // divider bit counter

  logic [W:0]     r_shift;
  logic           r_fits;
  logic [W-1:0]   r_step;
  logic [W-1:0]   q_step;
  logic [2*W-1:0] d_wide;

  // One restoring-division step: shift in the next dividend bit, subtract d if it fits.
  always_comb begin
    r_shift = {r, q[W-1]};
    r_fits  = (r_shift >= {1'b0, d});
    if (r_fits) begin
      // The true difference is below d, so the low W bits hold it exactly.
      r_step = r_shift[W-1:0] - d;
      q_step = {q[W-2:0], 1'b1};
    end else begin
      r_step = r_shift[W-1:0];
      q_step = {q[W-2:0], 1'b0};
    end
    d_wide = {{W{1'b0}}, d};
  end

  // Control FSM with registered handshake outputs; ready/error follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      error     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      factor    <= {W{1'b0}};
      n         <= {W{1'b0}};
      d         <= D_TWO;
      dsq       <= SQ_FOUR;
      q         <= {W{1'b0}};
      r         <= {W{1'b0}};
      cnt       <= {WIDTH_LOG{1'b0}};
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (go) begin
            n   <= num;
            d   <= D_TWO;
            dsq <= SQ_FOUR;
            if (num < D_TWO) begin
              state <= ERROR;
              ready <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= CHECK;
              ready <= 1'b0;
              error <= 1'b0;
            end
          end
        end

        CHECK: begin
          if (dsq > {{W{1'b0}}, n}) begin
            // No divisor up to sqrt(n) remains, so n itself is prime.
            factor    <= n;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
            state     <= EMIT_LAST;
          end else begin
            q     <= n;
            r     <= {W{1'b0}};
            cnt   <= {WIDTH_LOG{1'b0}};
            state <= DIV;
          end
        end

        DIV: begin
          q   <= q_step;
          r   <= r_step;
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            if (r_step == {W{1'b0}}) begin
              factor    <= d;
              out_last  <= (q_step == Q_ONE);
              out_valid <= 1'b1;
              n         <= q_step;
              state     <= EMIT;
            end else begin
              // Step 2 -> 3, then odd candidates; (d+2)^2 = d^2 + 4d + 4.
              if (d == D_TWO) begin
                d   <= D_THREE;
                dsq <= SQ_NINE;
              end else begin
                d   <= d + D_TWO;
                dsq <= dsq + (d_wide << 2) + SQ_FOUR;
              end
              state <= CHECK;
            end
          end
        end

        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              ready    <= 1'b1;
              error    <= 1'b0;
              state    <= IDLE;
            end else begin
              // Retry the same divisor to capture repeated factors.
              state <= CHECK;
            end
          end
        end

        EMIT_LAST: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ready     <= 1'b1;
            error     <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          ready     <= 1'b1;
          error     <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
